// File: rtl/grid_sweeper_pkg.sv
// Shared constants, state encoding and helpers for the grid sweeper.
// Module parameters default to these values so the defaults live in one place.
package grid_sweeper_pkg;

  localparam int DEF_X_BITS        = 8;
  localparam int DEF_Y_BITS        = 7;
  localparam int DEF_X_CELLS       = 160;
  localparam int DEF_Y_CELLS       = 120;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int SETTLE_W          = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WRITE,
    ADVANCE,
    DONE
  } sweep_state_t;

  // Eight-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/grid_sweeper_if.sv
// Control and status bundle between the game sequencer and the grid sweeper.
// The sweeper uses the slave side; whoever drives RUN/pause/tick uses master.
interface grid_sweeper_if
  import grid_sweeper_pkg::*;
#(
  parameter int X_bits = DEF_X_BITS,
  parameter int Y_bits = DEF_Y_BITS
);

  logic              RUN;
  logic              KEY_PAUSE;
  logic              game_tick;
  logic [X_bits-1:0] writeLoc_x;
  logic [Y_bits-1:0] writeLoc_y;
  logic              write_flag;
  logic              hold_locs;
  logic              busy;
  logic              sweep_done;
  logic [7:0]        overrun_cnt;

  modport master (
    output RUN, KEY_PAUSE, game_tick,
    input  writeLoc_x, writeLoc_y, write_flag, hold_locs, busy, sweep_done, overrun_cnt
  );

  modport slave (
    input  RUN, KEY_PAUSE, game_tick,
    output writeLoc_x, writeLoc_y, write_flag, hold_locs, busy, sweep_done, overrun_cnt
  );

endinterface

// File: rtl/grid_sweeper_settle_timer.sv
// Loadable down-counter that times the per-cell settle window.
// Load wins over hold; the count parks at zero until reloaded.
module grid_sweeper_settle_timer
  import grid_sweeper_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_value,
  input  logic                hold,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/grid_sweeper.sv
// Walks every grid cell once per game tick, giving the environment cache time
// to settle on each cell before issuing a single commit strobe.
module grid_sweeper
  import grid_sweeper_pkg::*;
#(
  parameter int X_bits        = DEF_X_BITS,
  parameter int Y_bits        = DEF_Y_BITS,
  parameter int X_CELLS       = DEF_X_CELLS,
  parameter int Y_CELLS       = DEF_Y_CELLS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic           Clk,
  input logic           Reset_n,
  grid_sweeper_if.slave sweep_bus
);

  localparam logic [X_bits-1:0]   X_LAST      = X_bits'(X_CELLS - 1);
  localparam logic [Y_bits-1:0]   Y_LAST      = Y_bits'(Y_CELLS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  sweep_state_t      state, state_next;
  logic [X_bits-1:0] x_q, x_next;
  logic [Y_bits-1:0] y_q, y_next;
  logic [7:0]        overrun_q, overrun_next;
  logic              write_flag_q, write_flag_next;
  logic              hold_locs_q, hold_locs_next;
  logic              busy_q, busy_next;
  logic              sweep_done_q, sweep_done_next;
  logic              settle_load, settle_hold, settle_zero;

  grid_sweeper_settle_timer settle_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .load       (settle_load),
    .load_value (SETTLE_LOAD),
    .hold       (settle_hold),
    .zero       (settle_zero)
  );

  // Every output is a register loaded from the next-state decode, so the
  // status flags always line up with the state they describe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      overrun_q    <= '0;
      write_flag_q <= 1'b0;
      hold_locs_q  <= 1'b1;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      x_q          <= x_next;
      y_q          <= y_next;
      overrun_q    <= overrun_next;
      write_flag_q <= write_flag_next;
      hold_locs_q  <= hold_locs_next;
      busy_q       <= busy_next;
      sweep_done_q <= sweep_done_next;
    end
  end

  always_comb begin
    state_next      = state;
    x_next          = x_q;
    y_next          = y_q;
    overrun_next    = overrun_q;
    sweep_done_next = 1'b0;
    settle_load     = 1'b0;
    settle_hold     = 1'b1;

    case (state)
      IDLE: begin
        if (sweep_bus.game_tick && sweep_bus.RUN && sweep_bus.KEY_PAUSE) begin
          state_next  = SETTLE;
          x_next      = '0;
          y_next      = '0;
          settle_load = 1'b1;
        end
      end
      SETTLE: begin
        if (sweep_bus.KEY_PAUSE) begin
          settle_hold = 1'b0;
          if (settle_zero) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        state_next = ADVANCE;
      end
      ADVANCE: begin
        // The final cell leaves the coordinates alone; DONE clears them.
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_next = DONE;
          end else begin
            x_next      = '0;
            y_next      = y_q + 1'b1;
            state_next  = SETTLE;
            settle_load = 1'b1;
          end
        end else begin
          x_next      = x_q + 1'b1;
          state_next  = SETTLE;
          settle_load = 1'b1;
        end
      end
      DONE: begin
        sweep_done_next = 1'b1;
        x_next          = '0;
        y_next          = '0;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (sweep_bus.game_tick && (state != IDLE)) begin
      overrun_next = sat_inc(overrun_q);
    end

    // Leaving run mode abandons the sweep outright, including a pending done pulse.
    if (!sweep_bus.RUN) begin
      state_next      = IDLE;
      x_next          = '0;
      y_next          = '0;
      sweep_done_next = 1'b0;
      settle_load     = 1'b0;
      settle_hold     = 1'b1;
    end

    write_flag_next = (state_next == WRITE);
    busy_next       = (state_next inside {SETTLE, WRITE, ADVANCE});
    hold_locs_next  = (state_next != ADVANCE);
  end

  assign sweep_bus.writeLoc_x  = x_q;
  assign sweep_bus.writeLoc_y  = y_q;
  assign sweep_bus.write_flag  = write_flag_q;
  assign sweep_bus.hold_locs   = hold_locs_q;
  assign sweep_bus.busy        = busy_q;
  assign sweep_bus.sweep_done  = sweep_done_q;
  assign sweep_bus.overrun_cnt = overrun_q;

endmodule

// File: tb/tb_grid_sweeper.sv
// Self-checking bench for grid_sweeper on a 4x2 grid with a 2-cycle settle.
// Expected commit times come from a per-cell walk of the settle/pause rules.
module tb_grid_sweeper;

  localparam int XC    = 4;
  localparam int YC    = 2;
  localparam int SC    = 2;
  localparam int NCELL = XC * YC;
  localparam int XB    = 8;
  localparam int YB    = 7;

  typedef struct {
    int c;
    int x;
    int y;
  } wr_t;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   exp_ovr = 0;

  wr_t  wq[$];
  int   dq[$];
  int   sq[$];
  int   hold_low  = 0;
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;

  grid_sweeper_if #(.X_bits(XB), .Y_bits(YB)) bus ();

  grid_sweeper #(
    .X_bits        (XB),
    .Y_bits        (YB),
    .X_CELLS       (XC),
    .Y_CELLS       (YC),
    .SETTLE_CYCLES (SC)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .sweep_bus (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (bus.write_flag === 1'b1) wq.push_back('{cyc, int'(bus.writeLoc_x), int'(bus.writeLoc_y)});
    if (bus.sweep_done === 1'b1) dq.push_back(cyc);
    if ((bus.busy === 1'b1) && !prev_busy) sq.push_back(cyc);
    prev_busy = (bus.busy === 1'b1);
    if (bus.hold_locs === 1'b0) hold_low++;
    if (bus.busy === 1'b1) busy_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] loc();
    return {17'd0, bus.writeLoc_x, bus.writeLoc_y};
  endfunction

  function automatic logic [31:0] loc_of(input int x, input int y);
    return 32'(x * (1 << YB) + y);
  endfunction

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wq.delete();
    dq.delete();
    sq.delete();
    hold_low = 0;
    busy_cnt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_write_flag"}, 32'(bus.write_flag), 0);
    check_output({tag, "_busy"}, 32'(bus.busy), 0);
    check_output({tag, "_hold_locs"}, 32'(bus.hold_locs), 1);
    check_output({tag, "_sweep_done"}, 32'(bus.sweep_done), 0);
    check_output({tag, "_overrun"}, 32'(bus.overrun_cnt), 0);
    check_output({tag, "_loc"}, loc(), 0);
  endtask

  // One full sweep: optional pause window, random overrun ticks, an optional
  // tick in the DONE cycle and optional ticking throughout the pause window.
  task automatic run_sweep(input int p0, input int plen, input int nrand,
                           input bit tick_done, input bit tick_pause);
    bit pz[0:511];
    bit tk[0:511];
    int wexp[NCELL];
    int t, n, done_rel, s, ticks;
    for (int r = 0; r < 512; r++) begin
      pz[r] = 1'b0;
      tk[r] = 1'b0;
    end
    for (int r = p0; r < p0 + plen; r++) pz[r] = 1'b1;

    // Each cell needs SC unpaused settle cycles, then a write and an advance cycle.
    t = 0;
    for (int c = 0; c < NCELL; c++) begin
      n = 0;
      while (n < SC) begin
        if (!pz[t]) n++;
        t++;
      end
      wexp[c] = t;
      t += 2;
    end
    done_rel = wexp[NCELL-1] + 2;

    if (tick_pause) for (int r = p0; r < p0 + plen; r++) tk[r] = 1'b1;
    for (int i = 0; i < nrand; i++) tk[$urandom_range(0, done_rel - 1)] = 1'b1;
    if (tick_done) tk[done_rel] = 1'b1;
    ticks = 0;
    for (int r = 0; r <= done_rel; r++) if (tk[r]) ticks++;
    exp_ovr = (exp_ovr + ticks > 255) ? 255 : exp_ovr + ticks;

    clear_log();
    bus.KEY_PAUSE = 1'b1;
    bus.game_tick = 1'b0;
    apply_stimulus($urandom_range(1, 4));
    bus.game_tick = 1'b1;
    s = cyc + 1;
    apply_stimulus(1);
    for (int r = 0; r <= done_rel + 6; r++) begin
      bus.KEY_PAUSE = !pz[r];
      bus.game_tick = tk[r];
      apply_stimulus(1);
    end
    bus.KEY_PAUSE = 1'b1;
    bus.game_tick = 1'b0;
    apply_stimulus(2);

    check_output("start_count", sq.size(), 1);
    check_output("start_cycle", (sq.size() > 0) ? sq[0] : -1, s);
    check_output("write_count", wq.size(), NCELL);
    for (int i = 0; i < NCELL; i++) begin
      check_output($sformatf("write%0d_cycle", i), (i < wq.size()) ? wq[i].c : -1, s + wexp[i]);
      check_output($sformatf("write%0d_loc", i),
                   (i < wq.size()) ? loc_of(wq[i].x, wq[i].y) : 32'hFFFF_FFFF,
                   loc_of(i % XC, i / XC));
    end
    check_output("done_count", dq.size(), 1);
    check_output("done_cycle", (dq.size() > 0) ? dq[0] : -1, s + done_rel + 1);
    check_output("advance_cycles", hold_low, NCELL);
    check_output("busy_cycles", busy_cnt, done_rel);
    check_output("overrun_cnt", 32'(bus.overrun_cnt), exp_ovr);
    check_output("idle_loc", loc(), 0);
    check_output("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    int s;
    bus.RUN       = 1'b1;
    bus.KEY_PAUSE = 1'b1;
    bus.game_tick = 1'b0;

    // Reset takes effect before the first clock edge.
    #2 Reset_n = 1'b0;
    #1 check_reset_values("por");
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    apply_stimulus(2);
    check_reset_values("post_release");

    $display("[TB] nominal sweep");
    run_sweep(0, 0, 0, 1'b0, 1'b0);

    $display("[TB] ten-cycle pause during settle of cell (2,0)");
    run_sweep(2 * (SC + 2), 10, 0, 1'b0, 1'b0);

    $display("[TB] random pause window with random overrun ticks");
    run_sweep($urandom_range(0, 30), $urandom_range(1, 12), 3, 1'b0, 1'b0);

    $display("[TB] tick coincident with DONE");
    run_sweep(0, 0, 0, 1'b1, 1'b0);

    $display("[TB] 300 ticks during one sweep");
    run_sweep(4, 300, 0, 1'b0, 1'b1);

    $display("[TB] RUN dropped at cell (1,1)");
    clear_log();
    bus.game_tick = 1'b1;
    s = cyc + 1;
    apply_stimulus(1);
    bus.game_tick = 1'b0;
    wait_until(s + 5 * (SC + 2));
    check_output("drop_loc_before", loc(), loc_of(1, 1));
    bus.RUN = 1'b0;
    apply_stimulus(1);
    check_output("drop_busy", 32'(bus.busy), 0);
    check_output("drop_loc", loc(), 0);
    check_output("drop_write_flag", 32'(bus.write_flag), 0);
    check_output("drop_hold_locs", 32'(bus.hold_locs), 1);
    bus.game_tick = 1'b1;
    apply_stimulus(1);
    bus.game_tick = 1'b0;
    apply_stimulus(40);
    check_output("drop_writes", wq.size(), 5);
    check_output("drop_no_done", dq.size(), 0);
    check_output("drop_no_restart", sq.size(), 1);
    bus.RUN       = 1'b1;
    bus.KEY_PAUSE = 1'b0;
    bus.game_tick = 1'b1;
    apply_stimulus(1);
    bus.game_tick = 1'b0;
    bus.KEY_PAUSE = 1'b1;
    apply_stimulus(3);
    check_output("paused_tick_ignored", sq.size(), 1);
    check_output("paused_tick_overrun", 32'(bus.overrun_cnt), exp_ovr);

    $display("[TB] asynchronous reset mid-sweep");
    clear_log();
    bus.game_tick = 1'b1;
    s = cyc + 1;
    apply_stimulus(1);
    bus.game_tick = 1'b0;
    wait_until(s + (SC + 2) + SC);
    check_output("pre_reset_write_flag", 32'(bus.write_flag), 1);
    #2 Reset_n = 1'b0;
    exp_ovr = 0;
    #1 check_reset_values("mid_reset");
    @(posedge Clk);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    apply_stimulus(40);
    check_output("reset_writes", wq.size(), 1);
    check_output("reset_no_done", dq.size(), 0);
    check_output("reset_idle_busy", 32'(bus.busy), 0);
    check_output("reset_overrun", 32'(bus.overrun_cnt), exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
